// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode/state types and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  localparam int MULDIV_ITERS = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle over magnitudes with sign fix-up
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d, op_in;
  logic [4:0]        cnt_q, cnt_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]   m_q, m_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              in_div, in_sa, in_sb, div_zero, ovf, carry, borrow;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, hi, diff, quo, rem, calc_res;
  logic [XLEN:0]     rem_w;
  logic [2*XLEN-1:0] mul_step, div_step, step, prod;
  // Operand decode, one multiply or divide iteration, sign fix-up and next-state selection.
  // m holds the multiplicand (multiply) or divisor (divide); acc starts with the other magnitude in its low half.
  always_comb begin
    op_in       = muldiv_op_e'(funct3);
    in_div      = funct3[2];
    in_sa       = (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM) && op_a[XLEN-1];
    in_sb       = (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM) && op_b[XLEN-1];
    abs_a       = in_sa ? -op_a : op_a;
    abs_b       = in_sb ? -op_b : op_b;
    div_zero    = in_div && op_b == '0;
    ovf         = (op_in == OP_DIV || op_in == OP_REM) && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
    special_res = div_zero ? (funct3[1] ? op_a : DIV_ZERO_Q) : (funct3[1] ? '0 : op_a);
    {carry, hi} = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? m_q : {XLEN{1'b0}}};
    mul_step    = {carry, hi, acc_q[XLEN-1:1]};
    rem_w       = acc_q[2*XLEN-1:XLEN-1];
    borrow      = rem_w < {1'b0, m_q};
    diff        = rem_w[XLEN-1:0] - m_q;
    div_step    = borrow ? {rem_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} : {diff, acc_q[XLEN-2:0], 1'b1};
    step        = op_q[2] ? div_step : mul_step;
    prod        = (sign_a_q ^ sign_b_q) ? -step : step;
    quo         = (sign_a_q ^ sign_b_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem         = sign_a_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    calc_res    = op_q == OP_MUL ? prod[XLEN-1:0] : !op_q[2] ? prod[2*XLEN-1:XLEN] : op_q[1] ? rem : quo;
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    m_d         = m_q;
    acc_d       = acc_q;
    result_d    = result_q;
    if (state_q == IDLE && start) begin
      op_d     = op_in;
      sign_a_d = in_sa;
      sign_b_d = in_sb;
      m_d      = in_div ? abs_b : abs_a;
      acc_d    = {{XLEN{1'b0}}, in_div ? abs_a : abs_b};
      cnt_d    = '0;
      state_d  = (div_zero || ovf) ? DONE : CALC;
      result_d = (div_zero || ovf) ? special_res : result_q;
    end else if (state_q == CALC) begin
      acc_d = step;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(MULDIV_ITERS - 1)) begin
        state_d  = DONE;
        result_d = calc_res;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers, cleared asynchronously so an in-flight operation is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  assign busy   = state_q == CALC;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for the iterative RV32M multiply/divide unit
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    string       n;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, ua, ub;
    logic [63:0] p;
    logic ov;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    ov   = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (f)
      3'd0:    begin p = ua * ub;   return p[31:0];  end
      3'd1:    begin p = sa * sb64; return p[63:32]; end
      3'd2:    begin p = sa * ub;   return p[63:32]; end
      3'd3:    begin p = ua * ub;   return p[63:32]; end
      3'd4:    return b == 0 ? 32'hFFFFFFFF : ov ? 32'h80000000 : 32'($signed(a) / $signed(b));
      3'd5:    return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6:    return b == 0 ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  // Waits (bounded) for done, counting edges and busy cycles from the current sample point.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Launches one operation, pushes its expectation, and pops it back when done appears.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        output int lat, output int bcnt, output logic [31:0] got, output logic [31:0] want,
                        output logic tail);
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    got  = result;
    want = sb.size() != 0 ? sb.pop_front() : 32'hDEADBEEF;
    @(posedge clk); #1;
    tail = done | busy;
  endtask

  task automatic test_reset;
    #3 rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_arith;
    vec_t v[$];
    int lat, bcnt;
    logic [31:0] got, want;
    logic tail;
    v = '{'{"mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
          '{"mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
          '{"mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
          '{"mulhsu_max",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
          '{"div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
          '{"rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
          '{"divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14},
          '{"remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2}};
    foreach (v[i]) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].r, lat, bcnt, got, want, tail);
      checks++; if (got !== want) begin errors++; $display("FAIL %s result got %h want %h", v[i].n, got, want); end
      checks++; if (lat !== 32) begin errors++; $display("FAIL %s latency got %0d want 32", v[i].n, lat); end
      checks++; if (bcnt !== 32) begin errors++; $display("FAIL %s busy_cycles got %0d want 32", v[i].n, bcnt); end
      checks++; if (tail !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", v[i].n, tail); end
    end
  endtask

  task automatic test_special;
    vec_t v[$];
    int lat, bcnt;
    logic [31:0] got, want;
    logic tail;
    v = '{'{"div_by_zero",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF},
          '{"remu_by_zero", 3'd7, 32'd5,        32'd0,        32'd5},
          '{"div_overflow", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
          '{"rem_overflow", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0}};
    foreach (v[i]) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].r, lat, bcnt, got, want, tail);
      checks++; if (got !== want) begin errors++; $display("FAIL %s result got %h want %h", v[i].n, got, want); end
      checks++; if (lat !== 0) begin errors++; $display("FAIL %s latency got %0d want 0", v[i].n, lat); end
      checks++; if (bcnt !== 0) begin errors++; $display("FAIL %s busy_cycles got %0d want 0", v[i].n, bcnt); end
      checks++; if (tail !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", v[i].n, tail); end
    end
  endtask

  task automatic test_random;
    int lat, bcnt, el;
    logic [31:0] a, b, got, want;
    logic [2:0] f;
    logic tail, sp;
    for (int i = 0; i < 16; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom();
      b  = $urandom_range(0, 4) == 0 ? 32'h0 : $urandom_range(0, 4) == 0 ? 32'hFFFFFFFF : $urandom();
      sp = f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
      el = sp ? 0 : 32;
      run_op(f, a, b, ref_model(f, a, b), lat, bcnt, got, want, tail);
      checks++; if (got !== want) begin errors++; $display("FAIL rand%0d f=%0d a=%h b=%h result got %h want %h", i, f, a, b, got, want); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt;
    logic [31:0] want;
    sb.push_back(32'd42);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    want = sb.size() != 0 ? sb.pop_front() : 32'hDEADBEEF;
    checks++; if (result !== want) begin errors++; $display("FAIL ignore_start result got %h want %h", result, want); end
    checks++; if (lat + 5 !== 32) begin errors++; $display("FAIL ignore_start latency got %0d want 32", lat + 5); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    logic [31:0] got, want;
    logic tail;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 00000000", result); end
    @(negedge clk) rstn = 1'b1;
    run_op(3'd0, 32'd6, 32'd7, 32'd42, lat, bcnt, got, want, tail);
    checks++; if (got !== want) begin errors++; $display("FAIL after_reset result got %h want %h", got, want); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL after_reset latency got %0d want 32", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    logic [31:0] want;
    sb.push_back(32'd14);
    sb.push_back(32'd42);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    wait_done(lat, bcnt);
    want = sb.size() != 0 ? sb.pop_front() : 32'hDEADBEEF;
    checks++; if (result !== want) begin errors++; $display("FAIL b2b_first result got %h want %h", result, want); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_first latency got %0d want 32", lat); end
    funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle busy_done got %b want 00", {busy, done}); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_relaunch busy got %b want 1", busy); end
    wait_done(lat, bcnt);
    want = sb.size() != 0 ? sb.pop_front() : 32'hDEADBEEF;
    checks++; if (result !== want) begin errors++; $display("FAIL b2b_second result got %h want %h", result, want); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_second latency got %0d want 32", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
